// File: rtl/gfx_pkg.sv
// Shared frame-buffer constants and drawing-engine state type.
// The scan-out side uses the same geometry, so keep these in sync with it.
package gfx_pkg;

  localparam int H_RES   = 640;  // visible pixels per row, also the VRAM row stride
  localparam int V_RES   = 480;  // visible rows
  localparam int ADDR_W  = 19;   // covers H_RES*V_RES = 307200 words
  localparam int COLOR_W = 12;   // RGB444

  localparam int X_W   = 10;     // column coordinate / width
  localparam int Y_W   = 9;      // row coordinate / height
  localparam int EXT_W = 11;     // x+w and y+h sums without overflow

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_FILL  = 2'd2
  } fill_state_t;

endpackage

// File: rtl/rect_clip.sv
// Combinational clip of a rectangle against the visible area, plus the
// linear VRAM address of the top row (y*640 built from two shifts).
module rect_clip
  import gfx_pkg::*;
(
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  input  logic [X_W-1:0]    w,
  input  logic [Y_W-1:0]    h,
  output logic [EXT_W-1:0]  x_end,
  output logic [EXT_W-1:0]  y_end,
  output logic [ADDR_W-1:0] row_base,
  output logic              empty
);

  localparam logic [EXT_W-1:0] H_LIM = EXT_W'(H_RES);
  localparam logic [EXT_W-1:0] V_LIM = EXT_W'(V_RES);

  logic [EXT_W-1:0]  x_sum;
  logic [EXT_W-1:0]  y_sum;
  logic [ADDR_W-1:0] y_ext;

  // Exclusive end coordinates clamped to the screen, empty detect, row base.
  always_comb begin
    x_sum    = {1'b0, x} + {1'b0, w};
    y_sum    = {2'b00, y} + {2'b00, h};
    x_end    = (x_sum > H_LIM) ? H_LIM : x_sum;
    y_end    = (y_sum > V_LIM) ? V_LIM : y_sum;
    y_ext    = ADDR_W'(y);
    row_base = (y_ext << 9) + (y_ext << 7);
    empty    = (w == '0) || (h == '0) ||
               ({1'b0, x} >= H_LIM) || ({2'b00, y} >= V_LIM);
  end

endmodule

// File: rtl/vram_rect_fill.sv
// Rectangle-fill engine: latches one command, clips it, then streams one
// solid-colour VRAM write per accepted cycle in raster order.
module vram_rect_fill
  import gfx_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [X_W-1:0]     cmd_x,
  input  logic [Y_W-1:0]     cmd_y,
  input  logic [X_W-1:0]     cmd_w,
  input  logic [Y_W-1:0]     cmd_h,
  input  logic [COLOR_W-1:0] cmd_color,
  output logic               vram_we,
  output logic [ADDR_W-1:0]  vram_waddr,
  output logic [COLOR_W-1:0] vram_wdata,
  input  logic               vram_stall,
  output logic               busy,
  output logic               done
);

  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_RES);

  fill_state_t state_reg, state_next;

  logic [X_W-1:0]     x_reg, x_next;
  logic [Y_W-1:0]     y_reg, y_next;
  logic [X_W-1:0]     w_reg, w_next;
  logic [Y_W-1:0]     h_reg, h_next;
  logic [COLOR_W-1:0] color_reg, color_next;
  logic [EXT_W-1:0]   x_end_reg, x_end_next;
  logic [EXT_W-1:0]   y_end_reg, y_end_next;
  logic [X_W-1:0]     cx_reg, cx_next;
  logic [Y_W-1:0]     cy_reg, cy_next;
  logic [ADDR_W-1:0]  row_base_reg, row_base_next;
  logic [ADDR_W-1:0]  addr_reg, addr_next;
  logic               we_reg, we_next;
  logic [COLOR_W-1:0] wdata_reg, wdata_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;

  logic [EXT_W-1:0]   clip_x_end;
  logic [EXT_W-1:0]   clip_y_end;
  logic [ADDR_W-1:0]  clip_row_base;
  logic               clip_empty;
  logic               accepted;
  logic [EXT_W-1:0]   cx_inc;
  logic [EXT_W-1:0]   cy_inc;

  rect_clip u_clip (
    .x        (x_reg),
    .y        (y_reg),
    .w        (w_reg),
    .h        (h_reg),
    .x_end    (clip_x_end),
    .y_end    (clip_y_end),
    .row_base (clip_row_base),
    .empty    (clip_empty)
  );

  assign cmd_ready  = (state_reg == ST_IDLE);
  assign vram_we    = we_reg;
  assign vram_waddr = addr_reg;
  assign vram_wdata = wdata_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state, pointer advance and registered-output decode.
  always_comb begin
    state_next    = state_reg;
    x_next        = x_reg;
    y_next        = y_reg;
    w_next        = w_reg;
    h_next        = h_reg;
    color_next    = color_reg;
    x_end_next    = x_end_reg;
    y_end_next    = y_end_reg;
    cx_next       = cx_reg;
    cy_next       = cy_reg;
    row_base_next = row_base_reg;
    addr_next     = addr_reg;
    we_next       = we_reg;
    wdata_next    = wdata_reg;
    done_next     = 1'b0;
    accepted      = we_reg & ~vram_stall;
    cx_inc        = {1'b0, cx_reg} + 1'b1;
    cy_inc        = {2'b00, cy_reg} + 1'b1;

    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          x_next     = cmd_x;
          y_next     = cmd_y;
          w_next     = cmd_w;
          h_next     = cmd_h;
          color_next = cmd_color;
          state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        x_end_next = clip_x_end;
        y_end_next = clip_y_end;
        if (clip_empty) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end else begin
          state_next    = ST_FILL;
          cx_next       = x_reg;
          cy_next       = y_reg;
          row_base_next = clip_row_base;
          addr_next     = clip_row_base + ADDR_W'(x_reg);
          we_next       = 1'b1;
          wdata_next    = color_reg;
        end
      end
      ST_FILL: begin
        // A stalled write leaves every register untouched.
        if (accepted) begin
          if (cx_inc < x_end_reg) begin
            cx_next   = cx_reg + 1'b1;
            addr_next = addr_reg + 1'b1;
          end else if (cy_inc < y_end_reg) begin
            cx_next       = x_reg;
            cy_next       = cy_reg + 1'b1;
            row_base_next = row_base_reg + H_STEP;
            addr_next     = row_base_reg + H_STEP + ADDR_W'(x_reg);
          end else begin
            state_next = ST_IDLE;
            we_next    = 1'b0;
            done_next  = 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        we_next    = 1'b0;
      end
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg        <= '0;
      y_reg        <= '0;
      w_reg        <= '0;
      h_reg        <= '0;
      color_reg    <= '0;
      x_end_reg    <= '0;
      y_end_reg    <= '0;
      cx_reg       <= '0;
      cy_reg       <= '0;
      row_base_reg <= '0;
      addr_reg     <= '0;
      we_reg       <= 1'b0;
      wdata_reg    <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      x_reg        <= x_next;
      y_reg        <= y_next;
      w_reg        <= w_next;
      h_reg        <= h_next;
      color_reg    <= color_next;
      x_end_reg    <= x_end_next;
      y_end_reg    <= y_end_next;
      cx_reg       <= cx_next;
      cy_reg       <= cy_next;
      row_base_reg <= row_base_next;
      addr_reg     <= addr_next;
      we_reg       <= we_next;
      wdata_reg    <= wdata_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

endmodule

// File: doc/vram_rect_fill.md
# vram_rect_fill

Drawing engine on the write side of the frame buffer: accepts one rectangle-fill command at a time and writes a solid 12-bit colour into every covered pixel of the 640x480 VRAM, one word per cycle. It sits between the command source (CPU bus bridge) and the VRAM write port; the scan-out GPU reads the same VRAM with `addr = col + 640*row`, and this block uses the identical linear mapping.

## Interface
- `H_RES`, 640, visible pixels per row; row stride in VRAM.
- `V_RES`, 480, visible rows.
- `ADDR_W`, 19, VRAM word-address width; must cover `H_RES*V_RES` = 307200.
- `COLOR_W`, 12, pixel width (RGB444).
- `clk`  in  1  single clock for the whole block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command; high exactly when the state is IDLE.
- `cmd_x`  in  10  left column.
- `cmd_y`  in  9  top row.
- `cmd_w`  in  10  width in pixels.
- `cmd_h`  in  9  height in rows.
- `cmd_color`  in  COLOR_W  fill colour.
- `vram_we`  out  1  write request.
- `vram_waddr`  out  ADDR_W  write word address.
- `vram_wdata`  out  COLOR_W  write data.
- `vram_stall`  in  1  write port busy; a write completes only when `vram_we & !vram_stall`.
- `busy`  out  1  high in SETUP and FILL.
- `done`  out  1  one-cycle pulse at command completion.

## Operation
- States: IDLE, SETUP, FILL.
- IDLE: `cmd_ready=1`. `cmd_valid & cmd_ready` latches all `cmd_*` fields -> SETUP.
- SETUP (1 cycle):
  - Clipped extents use 11-bit sums: `x_end = min(x+w, H_RES)`, `y_end = min(y+h, V_RES)`.
  - Row base is `y*640`, computed as `(y<<9)+(y<<7)`, with no multiplier.
  - Empty rectangle (`w==0`, `h==0`, `x>=H_RES` or `y>=V_RES`): go to IDLE; `done` pulses in the next cycle; no write is issued.
  - Otherwise: go to FILL with `cx=x`, `cy=y` and `addr = rowbase + x`.
- FILL:
  - `vram_we=1`, `vram_waddr=addr`, `vram_wdata=color`.
  - On an accepted write, the pointers advance. If `cx+1 < x_end`: `cx++` and `addr++`. Otherwise: `cx=x`, `cy++`, `rowbase += H_RES` and `addr = rowbase + H_RES + x`.
  - The accepted write at (`x_end-1`, `y_end-1`) -> IDLE with `done=1` in that IDLE cycle.
- Stall: while `vram_stall=1`, `vram_we`, `vram_waddr` and `vram_wdata` are held unchanged and the counters are frozen.
- Pixels are written in raster order (row-major, left to right).
- The block never writes outside `[0, H_RES)` x `[0, V_RES)`.
- `cmd_*` inputs are ignored outside IDLE; the latched copy is used throughout.

## Timing
- Reset values: state IDLE, `cmd_ready=1`, `busy=0`, `done=0`, `vram_we=0`, `vram_waddr=0`, `vram_wdata=0`.
- Accept in cycle 0 -> SETUP in cycle 1 -> first `vram_we` in cycle 2.
- Without stalls, an N-pixel clipped rectangle produces writes in cycles 2..N+1, `done` in cycle N+2, and the next accept in cycle N+2.
- Throughput is one pixel per cycle with no bubble at row wrap.
- `done` and `cmd_ready` are both high in the completion cycle, so a back-to-back command can be accepted in that cycle.
- All outputs are registered except `cmd_ready`, which is decoded from the state register.
- `rst_n` low mid-FILL: immediate return to IDLE; `vram_we` drops asynchronously, no `done` is issued and the in-flight command is discarded.

## Structure
- Shared package `gfx_pkg` holds `H_RES`, `V_RES`, `ADDR_W`, `COLOR_W`, the coordinate widths and the state enum `fill_state_t`. The scan-out GPU uses the same constants.
- One sub-module, `rect_clip`: combinational clip/extent and row-base calculation used by SETUP. The counters and FSM stay in the top module.

## Test plan
- Command (x=10, y=20, w=3, h=2, color=12'hF00), no stall -> 6 writes to addresses 12810,12811,12812,13450,13451,13452, all with data F00; `done` in cycle 8.
- Command (x=638, y=479, w=5, h=4) -> clipped; exactly 2 writes, to 307198 and 307199; `done` follows.
- w=0, or x=700 -> no `vram_we`; `done` 2 cycles after accept.
- (0,0,4,1) with `vram_stall` high for 3 cycles at the second write -> addr 1 held for 4 cycles; 4 writes total; `done` delayed by 3 cycles.
- Two commands back-to-back, the second with `cmd_valid` held -> second accepted in the first command's `done` cycle; no gap beyond the SETUP cycle.
- Assert `rst_n` low during the 3rd write of a 4x4 fill -> `vram_we=0` immediately and `cmd_ready=1`; after release a new command executes correctly.
